// File: rtl/spike_decoder_pkg.sv
// Shared types and helpers for the spike decoder: FSM states, width helpers
// and the saturating increment used by the per-neuron counters.
package spike_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int cls_width(input int num_outputs);
      return $clog2(num_outputs);
   endfunction

   // Step counter must be able to hold the value TIME_STEPS itself.
   function automatic int step_width(input int time_steps);
      return (time_steps < 2) ? 1 : $clog2(time_steps + 1);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] max_value;
      max_value = (32'd1 << width) - 32'd1;
      return (value == max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/spike_count_bank.sv
// Bank of NUM_OUTPUTS saturating spike counters with a single combinational
// read port; clear has priority over increment.
module spike_count_bank
   import spike_decoder_pkg::*;
#(
   parameter int NUM_OUTPUTS = 10,
   parameter int CNT_W       = 8,
   parameter int CLS_W       = cls_width(NUM_OUTPUTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   inc_en,
   input  logic [NUM_OUTPUTS-1:0] spikes,
   input  logic [CLS_W-1:0]       rd_idx,
   output logic [CNT_W-1:0]       rd_cnt
);

   logic [CNT_W-1:0] cnt [NUM_OUTPUTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
      end else if (inc_en) begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (spikes[i]) cnt[i] <= CNT_W'(sat_inc(32'(cnt[i]), CNT_W));
         end
      end
   end

   // Index range guard only matters when NUM_OUTPUTS is not a power of two.
   always_comb begin
      rd_cnt = '0;
      if (32'(rd_idx) < NUM_OUTPUTS) rd_cnt = cnt[rd_idx];
   end

endmodule

// File: rtl/spike_decoder.sv
// Counts output-layer spikes over a window, then scans serially for the
// argmax and presents the winning class under a valid/ready handshake.
module spike_decoder
   import spike_decoder_pkg::*;
#(
   parameter int NUM_OUTPUTS = 10,
   parameter int TIME_STEPS  = 100,
   parameter int CNT_W       = 8,
   parameter int CLS_W       = cls_width(NUM_OUTPUTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NUM_OUTPUTS-1:0] spike_in,
   input  logic                   spike_valid,
   output logic                   busy,
   output logic [CLS_W-1:0]       class_id,
   output logic [CNT_W-1:0]       max_count,
   output logic                   no_spike,
   output logic                   class_valid,
   input  logic                   class_ready
);

   localparam int STEP_W = step_width(TIME_STEPS);

   state_t            state, next_state;
   logic [STEP_W-1:0] step_cnt;
   logic [CLS_W-1:0]  scan_idx;
   logic [CLS_W-1:0]  best_idx;
   logic [CNT_W-1:0]  best_cnt;
   logic [CNT_W-1:0]  rd_cnt;
   logic              clear;
   logic              inc_en;
   logic              last_step;
   logic              last_idx;

   assign last_step = (step_cnt == STEP_W'(TIME_STEPS - 1));
   assign last_idx  = (scan_idx == CLS_W'(NUM_OUTPUTS - 1));

   spike_count_bank #(
      .NUM_OUTPUTS (NUM_OUTPUTS),
      .CNT_W       (CNT_W),
      .CLS_W       (CLS_W)
   ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .inc_en (inc_en),
      .spikes (spike_in),
      .rd_idx (scan_idx),
      .rd_cnt (rd_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      clear       = 1'b0;
      inc_en      = 1'b0;
      busy        = (state != IDLE);
      class_valid = (state == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               clear      = 1'b1;
               next_state = ACCUM;
            end
         end
         ACCUM: begin
            if (spike_valid) begin
               inc_en = 1'b1;
               if (last_step) next_state = SCAN;
            end
         end
         SCAN: begin
            if (last_idx) next_state = DONE;
         end
         DONE: begin
            if (class_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      step_cnt <= '0;
      else if (clear)  step_cnt <= '0;
      else if (inc_en) step_cnt <= step_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              scan_idx <= '0;
      else if (state != SCAN)  scan_idx <= '0;
      else if (!last_idx)      scan_idx <= scan_idx + 1'b1;
   end

   // Strict greater-than keeps the lowest index on ties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_idx <= '0;
         best_cnt <= '0;
      end else if (state == SCAN) begin
         if (scan_idx == '0 || rd_cnt > best_cnt) begin
            best_idx <= scan_idx;
            best_cnt <= rd_cnt;
         end
      end
   end

   assign class_id  = best_idx;
   assign max_count = best_cnt;
   assign no_spike  = class_valid && (best_cnt == '0);

endmodule

// File: tb/tb_spike_decoder.sv
// Directed bench for spike_decoder: main instance (10 classes, 100 steps,
// 8-bit counters) plus a small-counter instance for saturation.
module tb_spike_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, spike_valid, class_ready;
   logic [9:0] spike_in;
   logic       busy, no_spike, class_valid;
   logic [3:0] class_id;
   logic [7:0] max_count;

   logic       s_start, s_valid, s_ready;
   logic [9:0] s_spike_in;
   logic       s_busy, s_no_spike, s_class_valid;
   logic [3:0] s_class_id;
   logic [3:0] s_max_count;

   int tests = 0;
   int fails = 0;
   int k;

   always #5 clk = ~clk;

   spike_decoder #(.NUM_OUTPUTS(10), .TIME_STEPS(100), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .spike_in(spike_in),
      .spike_valid(spike_valid), .busy(busy), .class_id(class_id),
      .max_count(max_count), .no_spike(no_spike), .class_valid(class_valid),
      .class_ready(class_ready)
   );

   spike_decoder #(.NUM_OUTPUTS(10), .TIME_STEPS(20), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .spike_in(s_spike_in),
      .spike_valid(s_valid), .busy(s_busy), .class_id(s_class_id),
      .max_count(s_max_count), .no_spike(s_no_spike), .class_valid(s_class_valid),
      .class_ready(s_ready)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Start cycle carries spike_valid with all spikes set; it must not count.
   task automatic do_start();
      start = 1'b1; spike_valid = 1'b1; spike_in = '1;
      @(negedge clk);
      start = 1'b0; spike_valid = 1'b0; spike_in = '0;
   endtask

   // mode 0: n3 every step, n7 on even steps; mode 1: n2/n5 for first 40
   // steps with spiky gaps and a stray start; mode 2: silent.
   task automatic run_window(input int mode, input int n);
      logic [9:0] s;
      for (int i = 0; i < n; i++) begin
         s = '0;
         case (mode)
            0: begin s[3] = 1'b1; if (i % 2 == 0) s[7] = 1'b1; end
            1: if (i < 40) begin s[2] = 1'b1; s[5] = 1'b1; end
            default: ;
         endcase
         if (mode == 1 && i % 7 == 3) begin
            spike_valid = 1'b0; spike_in = '1; start = (i == 24);
            @(negedge clk);
            start = 1'b0;
         end
         spike_in = s; spike_valid = 1'b1;
         @(negedge clk);
      end
      spike_valid = 1'b0; spike_in = '0;
   endtask

   task automatic wait_result(output int cycles);
      cycles = 0;
      while (!class_valid && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic ack();
      class_ready = 1'b1;
      @(negedge clk);
      class_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; spike_valid = 1'b0; class_ready = 1'b0; spike_in = '0;
      s_start = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_spike_in = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", class_valid, 0);
      chk("rst_class", class_id, 0);
      chk("rst_max", max_count, 0);
      chk("rst_nospike", no_spike, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic classification, then stalled consumer with a stray start.
      do_start();
      chk("basic_busy", busy, 1);
      run_window(0, 100);
      wait_result(k);
      chk("basic_latency", k, 10);
      chk("basic_class", class_id, 3);
      chk("basic_max", max_count, 100);
      chk("basic_nospike", no_spike, 0);
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         @(negedge clk);
         start = 1'b0;
         chk("hold_valid", class_valid, 1);
         chk("hold_class", class_id, 3);
         chk("hold_max", max_count, 100);
      end
      ack();
      chk("ack_valid", class_valid, 0);
      chk("ack_busy", busy, 0);

      // Tie with gaps and a start inside ACCUM; start right after handshake.
      do_start();
      run_window(1, 100);
      wait_result(k);
      chk("tie_latency", k, 10);
      chk("tie_class", class_id, 2);
      chk("tie_max", max_count, 40);
      chk("tie_nospike", no_spike, 0);
      ack();

      // Silent window.
      do_start();
      run_window(2, 100);
      wait_result(k);
      chk("silent_valid", class_valid, 1);
      chk("silent_nospike", no_spike, 1);
      chk("silent_class", class_id, 0);
      chk("silent_max", max_count, 0);
      ack();

      // Saturation on the 4-bit counter instance.
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_spike_in = '0;
         s_spike_in[9] = 1'b1;
         if (i < 10) s_spike_in[1] = 1'b1;
         s_valid = 1'b1;
         @(negedge clk);
      end
      s_valid = 1'b0; s_spike_in = '0;
      k = 0;
      while (!s_class_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("sat_latency", k, 10);
      chk("sat_class", s_class_id, 9);
      chk("sat_max", s_max_count, 15);
      chk("sat_nospike", s_no_spike, 0);
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0;
      chk("sat_ack_busy", s_busy, 0);

      // Asynchronous reset mid-window, then a clean full window.
      do_start();
      run_window(0, 50);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", class_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      do_start();
      run_window(0, 100);
      wait_result(k);
      chk("post_latency", k, 10);
      chk("post_class", class_id, 3);
      chk("post_max", max_count, 100);
      ack();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spike_decoder.md
Name: spike_decoder

Overview:
- Output-side counterpart of the input spike encoder. It turns the spike trains from the output neuron layer back into a classification result.
- Over one inference window of TIME_STEPS time steps, it counts spikes per output neuron.
- It then scans the counts serially to find the argmax and presents the winning class with a valid/ready handshake.
- It sits between the last neuron layer and the result/host interface.

Parameters:
- NUM_OUTPUTS, 10, number of output neurons (classes); must be at least 2.
- TIME_STEPS, 100, time steps per inference window; must be at least 1.
- CNT_W, 8, width of each per-neuron spike counter; counters saturate.
- CLS_W, $clog2(NUM_OUTPUTS), width of the class index.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a new window; honoured only in IDLE.
- spike_in, input, NUM_OUTPUTS, one spike bit per output neuron for the current time step.
- spike_valid, input, 1, spike_in holds one time step; sampled only in ACCUM.
- busy, output, 1, high in ACCUM, SCAN and DONE.
- class_id, output, CLS_W, index of the winning neuron.
- max_count, output, CNT_W, spike count of the winner.
- no_spike, output, 1, high with the result when every count is zero.
- class_valid, output, 1, result valid.
- class_ready, input, 1, consumer accepts the result.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All counters, step counter and scan index go to 0.
  - busy=0, class_valid=0, class_id=0, max_count=0, no_spike=0.
  - Reset mid-window aborts the window with no result.
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - On start=1, clear all counters and the step counter, then enter ACCUM on the next edge.
  - spike_valid is ignored in IDLE, including in the start cycle.
- ACCUM, per cycle with spike_valid=1:
  - Each counter i increments when spike_in[i]=1.
  - A counter at 2^CNT_W-1 holds (saturates).
  - The step counter increments.
  - When the accepted step is number TIME_STEPS, enter SCAN on the same edge (that step's spikes are counted).
  - Cycles with spike_valid=0 do not advance anything.
  - start in ACCUM, SCAN or DONE is ignored.
- SCAN, one neuron per cycle, index 0 to NUM_OUTPUTS-1:
  - Running best starts at index 0 with its count.
  - A later index replaces the best only if its count is strictly greater, so ties go to the lowest index.
  - After index NUM_OUTPUTS-1 is evaluated, enter DONE.
  - class_valid rises exactly NUM_OUTPUTS cycles after the edge that accepted the final time step.
- DONE:
  - class_valid=1; class_id, max_count and no_spike are stable while class_valid=1.
  - no_spike=1 iff max_count==0, in which case class_id=0.
  - On class_valid and class_ready both high at an edge, return to IDLE with class_valid=0. Outputs keep their last values after this; their values are don't-care.
  - Back-to-back operation: start may arrive in the cycle after the handshake. Minimum turnaround is 1 idle cycle.
- Counters are not cleared at the end of a window, only on start. This allows debug readback via hierarchy.

Decomposition:
- Package spike_decoder_pkg holds:
  - the state enum (IDLE, ACCUM, SCAN, DONE);
  - the localparam helpers for CLS_W and the step-counter width ($clog2(TIME_STEPS+1));
  - the saturating-increment function.
- Sub-module spike_count_bank holds NUM_OUTPUTS saturating counters.
  - Inputs: clear, inc_en, spike vector, read index.
  - Output: the count at the read index, used by the SCAN comparator.
- The top level contains the FSM, the step counter and the argmax register.

Test Plan:
- Basic classification (NUM_OUTPUTS=10, TIME_STEPS=100): start, then 100 valid steps with neuron 3 spiking every step and neuron 7 every other step -> class_id=3, max_count=100, no_spike=0. class_valid rises 10 cycles after the 100th valid edge.
- Tie-break: neurons 2 and 5 each spike 40 times, all others 0 -> class_id=2, max_count=40.
- Saturation (CNT_W=4, TIME_STEPS=20): neuron 9 spikes every step -> max_count=15, class_id=9.
- Silent window: 100 steps with spike_in=0 -> no_spike=1, class_id=0, max_count=0.
- Handshake and ignored inputs:
  - hold class_ready=0 for 5 cycles -> outputs stable, class_valid held;
  - start pulses during ACCUM and DONE -> no effect;
  - gaps in spike_valid do not advance the step counter;
  - handshake -> IDLE; the next start clears counts from the previous window.
- Reset mid-operation: assert rst_n=0 at step 50 -> busy=0 and class_valid=0 immediately (asynchronous). A following full window classifies correctly with no residual counts.
